pc_fetch_stage: RTL and testbench
=================================

Name: pc_fetch_stage

Overview:
- Program-counter register and instruction-fetch stage that consumes the 32-bit next-PC selected by the next-PC mux.
- Produces pc_plus4, which feeds the mux's sequential (+4) input.
- Runs a request/ready handshake with instruction memory and loads the IF/ID pipeline register.
- Supports stall (hold) and redirect (flush) for jumps and branches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on reset and flush

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
next_pc  input  32  next-PC mux output
pc_redirect  input  1  non-sequential target (jump/jr/branch) resolved this cycle; flush and load next_pc
stall  input  1  hazard unit hold request for PC and IF/ID
imem_req  output  1  instruction-memory request valid
imem_addr  output  32  fetch address, always equal to pc
imem_rdata  input  32  instruction word, valid when imem_ready is 1
imem_ready  input  1  completes the transaction on the rising edge where imem_req=1
pc  output  32  current fetch PC
pc_plus4  output  32  pc + 4, combinational
ifid_instr  output  32  IF/ID instruction
ifid_pc_plus4  output  32  IF/ID copy of pc + 4
ifid_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, level): state=IDLE, pc=RESET_PC, imem_req=0, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc_plus4=0, hold buffer cleared. Reset mid-transaction aborts it; instruction memory must tolerate req dropping.
- pc_plus4 = pc + 32'd4, wraps modulo 2^32 (32'hFFFF_FFFC gives 0). imem_addr = pc.
- imem_req=1 only in FETCH and KILL. While req=1 and not ready, addr is held stable.
- States:
  - IDLE: always goes to FETCH on the next edge.
  - FETCH, ready=1, redirect=0, stall=0: IF/ID <= {rdata, pc+4, valid=1}; pc <= next_pc; stay in FETCH. Throughput is 1 instruction/cycle with zero-wait memory.
  - FETCH, ready=1, redirect=0, stall=1: rdata and pc+4 go into the hold buffer; IF/ID unchanged; pc unchanged; go to HOLD.
  - FETCH, ready=0, redirect=0: wait. stall has no effect.
  - HOLD (req=0): if stall=0 and redirect=0, IF/ID <= hold buffer with valid=1, pc <= next_pc, go to FETCH. If stall=1, stay in HOLD.
  - KILL (req=1 at the old address): discards the outstanding response. On ready=1, go to FETCH. pc already holds the redirect target.
- Redirect (pc_redirect=1) has top priority over stall and ready:
  - Always: pc <= next_pc, ifid_valid <= 0, ifid_instr <= NOP_INSTR.
  - FETCH with ready=1: data discarded; next state FETCH.
  - FETCH with ready=0: next state KILL; imem_addr stays at the old pc until done, then the new pc is used.
  - HOLD: hold buffer dropped; next state FETCH.
  - KILL: pc reloads with the new target; stays in KILL, or goes to FETCH if ready=1.
- stall=1 with no redirect: pc and IF/ID registers hold their values.
- Latency: a request issued at cycle N with ready at N gives ifid_valid=1 after edge N.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - Any value loaded into pc has bits [1:0] forced to 0.
  - Extra output pc_misaligned (1 bit, reset 0) goes high and stays high when a loaded next_pc has non-zero bits [1:0].
  - pc_misaligned is cleared only by reset.
- When undefined: next_pc is loaded unmodified and the port is absent.

Decomposition:
- Package mips_fetch_pkg holds:
  - fetch_state_t enum {IDLE, FETCH, HOLD, KILL}, 2 bits;
  - localparam PC_INC = 32'd4;
  - default NOP_INSTR and RESET_PC constants.
- One sub-module, ifid_pipe_reg: 32-bit instr, 32-bit pc_plus4 and a valid bit, with load, hold and flush inputs; flush has priority over load.
- The FSM, pc register and hold buffer stay in pc_fetch_stage.

Test Plan:
- Reset, then 3 cycles with ready tied 1 and next_pc=pc_plus4 → imem_addr 0,4,8; ifid_pc_plus4 4,8,C with ifid_valid=1.
- Memory with 2 wait states at pc=0x10 → req high with addr stable at 0x10 for 3 cycles; pc becomes 0x14 one edge after ready; no duplicate IF/ID load.
- Ready returned while stall=1 → HOLD, req=0, pc and IF/ID frozen; after stall drops, ifid_instr = the held word and pc advances once.
- Redirect to 0x40 during a pending wait at 0x20 → ifid_valid=0; the late response is discarded; the next request uses addr 0x40.
- Redirect and stall together, then pc=32'hFFFF_FFFC → flush wins and pc=target; pc_plus4=0 wraps.
- With PC_ALIGN_CHECK_EN defined, next_pc=0x46 → pc=0x44 and pc_misaligned sticks at 1 until reset.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Optional build macro PC_ALIGN_CHECK_EN enables PC alignment forcing
// and the sticky pc_misaligned flag in pc_fetch_stage.
package mips_fetch_pkg;

  // Fetch sequencer states:
  //   IDLE  - first cycle out of reset, no request yet
  //   FETCH - request outstanding at pc
  //   HOLD  - response captured while stalled, waiting to enter IF/ID
  //   KILL  - draining a response that a redirect made stale
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    KILL  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_INC            = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  // Word-align an address by clearing its byte-offset bits.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // True when an address has a non-zero byte offset.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: instruction word, its pc+4 and a valid bit.
// Priority is flush > hold > load; flush inserts NOP_INSTR and clears
// valid while leaving the stored pc+4 untouched.
module ifid_pipe_reg
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc_plus4,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // Register update with flush taking precedence over hold and load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr    <= NOP_INSTR;
      valid    <= 1'b0;
    end else if (hold) begin
      instr    <= instr;
      pc_plus4 <= pc_plus4;
      valid    <= valid;
    end else if (load) begin
      instr    <= load_instr;
      pc_plus4 <= load_pc_plus4;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// Program counter, instruction-memory request/ready sequencer, hold
// buffer for responses that arrive during a stall, and the IF/ID register.
// Optional build macro PC_ALIGN_CHECK_EN: loaded PC values are word
// aligned and the sticky pc_misaligned output reports any unaligned load.
module pc_fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        pc_redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
`ifdef PC_ALIGN_CHECK_EN
  output logic        pc_misaligned,
`endif
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
);

  fetch_state_t state;
  fetch_state_t state_next;

  logic [31:0] hold_instr;
  logic [31:0] hold_pc_plus4;
  logic [31:0] kill_addr;
  logic [31:0] pc_load_value;

  logic pc_load;
  logic hold_capture;
  logic kill_capture;
  logic ifid_load;
  logic [31:0] ifid_load_instr;
  logic [31:0] ifid_load_pc_plus4;

  // Sequential successor address; wraps naturally at 2^32.
  always_comb begin
    pc_plus4 = pc + PC_INC;
  end

  // While a stale request drains, the address stays on the old pc even
  // though pc already holds the redirect target.
  always_comb begin
    imem_addr = (state == KILL) ? kill_addr : pc;
  end

  // Value written into pc whenever it is loaded from the next-PC mux.
  always_comb begin
`ifdef PC_ALIGN_CHECK_EN
    pc_load_value = align_pc(next_pc);
`else
    pc_load_value = next_pc;
`endif
  end

  // Next-state and datapath-enable decode; redirect outranks stall/ready.
  always_comb begin
    state_next   = state;
    pc_load      = 1'b0;
    hold_capture = 1'b0;
    kill_capture = 1'b0;
    if (pc_redirect) begin
      pc_load = 1'b1;
      unique case (state)
        IDLE:  state_next = FETCH;
        FETCH: begin
          if (imem_ready) begin
            state_next = FETCH;
          end else begin
            state_next   = KILL;
            kill_capture = 1'b1;
          end
        end
        HOLD:  state_next = FETCH;
        KILL:  state_next = imem_ready ? FETCH : KILL;
        default: state_next = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE:  state_next = FETCH;
        FETCH: begin
          if (imem_ready) begin
            if (stall) begin
              state_next   = HOLD;
              hold_capture = 1'b1;
            end else begin
              pc_load = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            state_next = FETCH;
            pc_load    = 1'b1;
          end
        end
        KILL:  state_next = imem_ready ? FETCH : KILL;
        default: state_next = IDLE;
      endcase
    end
  end

  // IF/ID load source: live memory data in FETCH, buffered data in HOLD.
  always_comb begin
    ifid_load          = 1'b0;
    ifid_load_instr    = imem_rdata;
    ifid_load_pc_plus4 = pc_plus4;
    unique case (state)
      FETCH: ifid_load = imem_ready && !stall;
      HOLD: begin
        ifid_load          = !stall;
        ifid_load_instr    = hold_instr;
        ifid_load_pc_plus4 = hold_pc_plus4;
      end
      default: ifid_load = 1'b0;
    endcase
  end

  // Fetch FSM with registered request, pc, hold buffer and kill address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      imem_req      <= 1'b0;
      pc            <= RESET_PC;
      hold_instr    <= '0;
      hold_pc_plus4 <= '0;
      kill_addr     <= '0;
    end else begin
      state    <= state_next;
      imem_req <= (state_next == FETCH) || (state_next == KILL);
      if (pc_load) begin
        pc <= pc_load_value;
      end
      if (hold_capture) begin
        hold_instr    <= imem_rdata;
        hold_pc_plus4 <= pc_plus4;
      end
      if (kill_capture) begin
        kill_addr <= pc;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Sticky flag: set by any unaligned value loaded into pc, reset-only clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_misaligned <= 1'b0;
    end else if (pc_load && is_misaligned(next_pc)) begin
      pc_misaligned <= 1'b1;
    end
  end
`endif

  ifid_pipe_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid (
    .clk          (clk),
    .reset        (reset),
    .load         (ifid_load),
    .hold         (stall),
    .flush        (pc_redirect),
    .load_instr   (ifid_load_instr),
    .load_pc_plus4(ifid_load_pc_plus4),
    .instr        (ifid_instr),
    .pc_plus4     (ifid_pc_plus4),
    .valid        (ifid_valid)
  );

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios with literal
// expectations, then randomized stall/redirect/ready traffic against a
// transaction-level model of the fetch stage.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic        pc_redirect;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
`ifdef PC_ALIGN_CHECK_EN
  logic        pc_misaligned;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .next_pc      (next_pc),
    .pc_redirect  (pc_redirect),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
`ifdef PC_ALIGN_CHECK_EN
    .pc_misaligned(pc_misaligned),
`endif
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid   (ifid_valid)
  );

  // Transaction-level model: whether fetching has started, whether a
  // captured-but-undelivered word is parked, whether a stale response
  // is still owed by memory, plus the architectural registers.
  logic        m_started;
  logic        m_parked;
  logic [31:0] m_park_word;
  logic [31:0] m_park_p4;
  logic        m_stale;
  logic [31:0] m_stale_addr;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_p4;
  logic        m_mis;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] model_addr();
    return m_stale ? m_stale_addr : m_pc;
  endfunction

  function automatic logic [31:0] loaded(input logic [31:0] v);
`ifdef PC_ALIGN_CHECK_EN
    return v & 32'hFFFF_FFFC;
`else
    return v;
`endif
  endfunction

  task automatic model_reset();
    m_started = 1'b0; m_parked = 1'b0; m_stale = 1'b0;
    m_park_word = '0; m_park_p4 = '0; m_stale_addr = '0;
    m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_p4 = 32'h0;
    m_mis = 1'b0;
  endtask

  task automatic take_pc(input logic [31:0] v);
    if (v[1:0] != 2'b00) m_mis = 1'b1;
    m_pc = loaded(v);
  endtask

  task automatic squash();
    m_valid = 1'b0;
    m_instr = 32'h0;
  endtask

  // Apply one clock edge of the specification's rules to the model.
  task automatic model_edge(input logic rd, input logic st, input logic rdy,
                            input logic [31:0] np, input logic [31:0] rdata);
    logic [31:0] old_pc;
    old_pc = m_pc;
    if (!m_started) begin
      m_started = 1'b1;
      if (rd) begin take_pc(np); squash(); end
    end else if (m_parked) begin
      if (rd) begin
        m_parked = 1'b0; take_pc(np); squash();
      end else if (!st) begin
        m_parked = 1'b0;
        m_instr = m_park_word; m_p4 = m_park_p4; m_valid = 1'b1;
        take_pc(np);
      end
    end else if (m_stale) begin
      if (rd) begin take_pc(np); squash(); end
      if (rdy) m_stale = 1'b0;
    end else begin
      if (rd) begin
        take_pc(np); squash();
        if (!rdy) begin m_stale = 1'b1; m_stale_addr = old_pc; end
      end else if (rdy) begin
        if (st) begin
          m_parked = 1'b1; m_park_word = rdata; m_park_p4 = old_pc + 32'd4;
        end else begin
          m_instr = rdata; m_p4 = old_pc + 32'd4; m_valid = 1'b1;
          take_pc(np);
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("imem_req", {31'd0, imem_req}, {31'd0, m_started && !m_parked});
    check("imem_addr", imem_addr, model_addr());
    check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    check("ifid_instr", ifid_instr, m_instr);
    check("ifid_pc_plus4", ifid_pc_plus4, m_p4);
`ifdef PC_ALIGN_CHECK_EN
    check("pc_misaligned", {31'd0, pc_misaligned}, {31'd0, m_mis});
`endif
  endtask

  // Drive one cycle of inputs (called at a negedge), clock it, update the
  // model, compare just after the edge, and return at the next negedge.
  task automatic step(input logic rd, input logic st, input logic rdy, input logic [31:0] np);
    pc_redirect = rd;
    stall       = st;
    imem_ready  = rdy;
    next_pc     = np;
    imem_rdata  = rdy ? mem_word(model_addr()) : $urandom;
    @(posedge clk);
    model_edge(rd, st, rdy, np, imem_rdata);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic seq(input logic st, input logic rdy);
    step(1'b0, st, rdy, m_pc + 32'd4);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pc_redirect = 1'b0; stall = 1'b0;
    imem_ready = 1'b0; next_pc = '0; imem_rdata = '0;
    model_reset();
    #7;
    compare_all();
    check("lit_reset_pc", pc, 32'h0);
    check("lit_reset_pc_plus4", pc_plus4, 32'h4);
    check("lit_reset_valid", {31'd0, ifid_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Sequential fetch with zero-wait memory.
    seq(1'b0, 1'b1);
    check("lit_addr_0", imem_addr, 32'h0);
    check("lit_req_on", {31'd0, imem_req}, 32'h1);
    seq(1'b0, 1'b1);
    check("lit_addr_4", imem_addr, 32'h4);
    check("lit_ifid_p4_4", ifid_pc_plus4, 32'h4);
    seq(1'b0, 1'b1);
    check("lit_addr_8", imem_addr, 32'h8);
    check("lit_ifid_p4_8", ifid_pc_plus4, 32'h8);
    seq(1'b0, 1'b1);
    check("lit_ifid_p4_c", ifid_pc_plus4, 32'hC);
    check("lit_ifid_valid", {31'd0, ifid_valid}, 32'h1);
    seq(1'b0, 1'b1);
    check("lit_addr_10", imem_addr, 32'h10);

    // Two wait states at 0x10.
    seq(1'b0, 1'b0);
    check("lit_wait_addr1", imem_addr, 32'h10);
    seq(1'b0, 1'b0);
    check("lit_wait_addr2", imem_addr, 32'h10);
    check("lit_wait_p4", ifid_pc_plus4, 32'h10);
    seq(1'b0, 1'b1);
    check("lit_wait_pc", pc, 32'h14);
    check("lit_wait_instr", ifid_instr, mem_word(32'h10));

    // Response while stalled parks the word.
    seq(1'b1, 1'b1);
    check("lit_hold_req", {31'd0, imem_req}, 32'h0);
    check("lit_hold_pc", pc, 32'h14);
    seq(1'b1, 1'b1);
    check("lit_hold_p4", ifid_pc_plus4, 32'h14);
    seq(1'b0, 1'b0);
    check("lit_release_instr", ifid_instr, mem_word(32'h14));
    check("lit_release_pc", pc, 32'h18);

    // Redirect during a wait at 0x20.
    seq(1'b0, 1'b1);
    seq(1'b0, 1'b1);
    check("lit_pc_20", pc, 32'h20);
    seq(1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h40);
    check("lit_kill_valid", {31'd0, ifid_valid}, 32'h0);
    check("lit_kill_addr", imem_addr, 32'h20);
    check("lit_kill_pc", pc, 32'h40);
    seq(1'b0, 1'b1);
    check("lit_after_kill_addr", imem_addr, 32'h40);
    check("lit_after_kill_valid", {31'd0, ifid_valid}, 32'h0);
    seq(1'b0, 1'b1);
    check("lit_target_p4", ifid_pc_plus4, 32'h44);
    check("lit_target_instr", ifid_instr, mem_word(32'h40));

    // Redirect together with stall, into the top of the address space.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    check("lit_wrap_pc", pc, 32'hFFFF_FFFC);
    check("lit_wrap_plus4", pc_plus4, 32'h0);
    check("lit_wrap_valid", {31'd0, ifid_valid}, 32'h0);
    seq(1'b0, 1'b1);
    check("lit_wrap_ifid_p4", ifid_pc_plus4, 32'h0);

`ifdef PC_ALIGN_CHECK_EN
    step(1'b1, 1'b0, 1'b1, 32'h46);
    check("lit_align_pc", pc, 32'h44);
    check("lit_mis_set", {31'd0, pc_misaligned}, 32'h1);
    seq(1'b0, 1'b1);
    seq(1'b0, 1'b1);
    check("lit_mis_sticky", {31'd0, pc_misaligned}, 32'h1);
    do_reset();
    check("lit_mis_cleared", {31'd0, pc_misaligned}, 32'h0);
`endif

    // Randomized traffic, with occasional asynchronous resets mid-run.
    for (int i = 0; i < 3000; i++) begin
      logic        rd;
      logic [31:0] np;
      if (i % 700 == 350) do_reset();
      rd = ($urandom % 8) == 0;
      np = m_pc + 32'd4;
      if (rd) begin
        np = $urandom;
        if (($urandom % 4) != 0) np[1:0] = 2'b00;
      end
      step(rd, ($urandom % 4) == 0, ($urandom % 3) != 0, np);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
